// File: rtl/vga_bounce_box_gen.sv
// vga_bounce_box_gen: pixel generator that draws a solid square bouncing off
// the visible-area edges on a flat background. The box moves once per frame
// at the first blanking line. The pixel colour is registered on p_tick.
module vga_bounce_box_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned BOX_SIZE  = 32,
    parameter int unsigned VEL       = 2,
    parameter logic [11:0] BG_COLOR  = 12'h222
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic [11:0] color,
    input  logic        pause,
    output logic [11:0] rgb,
    output logic        frame_tick,
    output logic [7:0]  frame_cnt
);

    // All geometry arithmetic is 11 bits wide so box+size+vel cannot wrap.
    localparam logic [10:0] H_LIM = 11'(H_DISPLAY);
    localparam logic [10:0] V_LIM = 11'(V_DISPLAY);
    localparam logic [10:0] BOX11 = 11'(BOX_SIZE);
    localparam logic [10:0] VEL11 = 11'(VEL);

    logic [9:0]  box_x_q, box_x_d;
    logic [9:0]  box_y_q, box_y_d;
    logic        dir_x_q, dir_x_d;   // 1: moving towards larger coordinates
    logic        dir_y_q, dir_y_d;
    logic [11:0] color_q;
    logic [7:0]  frame_cnt_q;
    logic        frame_tick_q;
    logic [11:0] rgb_q, rgb_d;
    logic        refr;
    logic        in_box;
    logic [10:0] step_x, step_y;

    // One axis of motion; returns {next_dir, next_pos}. Clamps to the edge
    // on the frame that would overshoot and reverses there.
    function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic dir,
                                              input logic [10:0] limit);
        logic [10:0] p;
        logic [10:0] edge_pos;
        p        = {1'b0, pos};
        edge_pos = limit - BOX11;
        if (dir) begin
            if (p + BOX11 + VEL11 > limit) begin
                return {1'b0, edge_pos[9:0]};
            end
            p = p + VEL11;
            return {1'b1, p[9:0]};
        end
        if (p < VEL11) begin
            return {1'b1, 10'd0};
        end
        p = p - VEL11;
        return {1'b0, p[9:0]};
    endfunction

    // Frame update strobe: first pixel of the first blanking line.
    always_comb begin
        refr = p_tick && (x == 10'd0) && ({1'b0, y} == V_LIM);
    end

    // Next box position and direction; held while paused.
    always_comb begin
        step_x  = axis_step(box_x_q, dir_x_q, H_LIM);
        step_y  = axis_step(box_y_q, dir_y_q, V_LIM);
        box_x_d = box_x_q;
        box_y_d = box_y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (refr && !pause) begin
            box_x_d = step_x[9:0];
            dir_x_d = step_x[10];
            box_y_d = step_y[9:0];
            dir_y_d = step_y[10];
        end
    end

    // Pixel colour: half-open box test against the current position.
    always_comb begin
        in_box = ({1'b0, x} >= {1'b0, box_x_q}) && ({1'b0, x} < {1'b0, box_x_q} + BOX11) &&
                 ({1'b0, y} >= {1'b0, box_y_q}) && ({1'b0, y} < {1'b0, box_y_q} + BOX11);
        rgb_d  = rgb_q;
        if (p_tick) begin
            if (!video_on) begin
                rgb_d = 12'h000;
            end else if (in_box) begin
                rgb_d = color_q;
            end else begin
                rgb_d = BG_COLOR;
            end
        end
    end

    // Box state, colour latch and frame counter; these change only at refr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            box_x_q     <= '0;
            box_y_q     <= '0;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            color_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            box_x_q <= box_x_d;
            box_y_q <= box_y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
            if (refr) begin
                color_q     <= color;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    // Registered outputs: pixel colour and the delayed frame strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q        <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            rgb_q        <= rgb_d;
            frame_tick_q <= refr;
        end
    end

    assign rgb        = rgb_q;
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vga_bounce_box_gen.sv
// Bench for vga_bounce_box_gen: the driver pushes hand-computed expected
// outputs for every p_tick; a monitor pops and compares one clock later and
// checks that outputs hold on cycles without a p_tick.
module tb_vga_bounce_box_gen;

    localparam logic [11:0] BG = 12'h222;

    typedef struct packed {
        logic [11:0] rgb;
        logic        ft;
        logic [7:0]  fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        p_tick = 1'b0;
    logic        video_on = 1'b0;
    logic [9:0]  x = '0;
    logic [9:0]  y = '0;
    logic [11:0] color = '0;
    logic        pause = 1'b0;
    logic [11:0] rgb;
    logic        frame_tick;
    logic [7:0]  frame_cnt;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [7:0]  exp_fcnt = '0;
    logic        pend;
    logic [11:0] hold_rgb = '0;
    logic [7:0]  hold_fc = '0;

    vga_bounce_box_gen dut (
        .clk        (clk),
        .reset      (reset),
        .p_tick     (p_tick),
        .video_on   (video_on),
        .x          (x),
        .y          (y),
        .color      (color),
        .pause      (pause),
        .rgb        (rgb),
        .frame_tick (frame_tick),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // p_tick seen at a rising edge means fresh outputs at the next falling edge.
    always @(posedge clk or posedge reset) begin
        if (reset) pend <= 1'b0;
        else       pend <= p_tick;
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            hold_rgb = '0;
            hold_fc  = '0;
        end else if (pend) begin
            if (q.size() == 0) begin
                chk("unexpected_ptick", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("rgb", 32'(rgb), 32'(e.rgb));
                chk("frame_tick", 32'(frame_tick), 32'(e.ft));
                chk("frame_cnt", 32'(frame_cnt), 32'(e.fc));
                hold_rgb = e.rgb;
                hold_fc  = e.fc;
            end
        end else begin
            chk("rgb_hold", 32'(rgb), 32'(hold_rgb));
            chk("frame_tick_idle", 32'(frame_tick), 32'd0);
            chk("frame_cnt_hold", 32'(frame_cnt), 32'(hold_fc));
        end
    end

    task automatic pix(input int px, input int py, input logic von, input logic [11:0] er);
        exp_t e;
        @(negedge clk);
        x        = 10'(px);
        y        = 10'(py);
        video_on = von;
        p_tick   = 1'b1;
        e.rgb = er;
        e.ft  = 1'b0;
        e.fc  = exp_fcnt;
        q.push_back(e);
        @(negedge clk);
        p_tick = 1'b0;
    endtask

    task automatic frame(input logic [11:0] col, input logic pz);
        exp_t e;
        @(negedge clk);
        x        = 10'd0;
        y        = 10'd480;
        video_on = 1'b0;
        color    = col;
        pause    = pz;
        p_tick   = 1'b1;
        exp_fcnt = exp_fcnt + 8'd1;
        e.rgb = 12'h000;
        e.ft  = 1'b1;
        e.fc  = exp_fcnt;
        q.push_back(e);
        @(negedge clk);
        p_tick = 1'b0;
        pause  = 1'b0;
    endtask

    // Box corners inside, and one pixel beyond each edge outside.
    task automatic probe_box(input int bx, input int by, input logic [11:0] col);
        pix(bx, by, 1'b1, col);
        pix(bx + 31, by + 31, 1'b1, col);
        if (bx > 0) pix(bx - 1, by, 1'b1, BG);
        pix(bx + 32, by, 1'b1, BG);
        if (by > 0) pix(bx, by - 1, 1'b1, BG);
        pix(bx, by + 32, 1'b1, BG);
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        chk("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rgb", 32'(rgb), 32'h0);
        chk("reset_frame_tick", 32'(frame_tick), 32'h0);
        chk("reset_frame_cnt", 32'(frame_cnt), 32'h0);
        reset = 1'b0;

        // Box at (0,0) with colour 000 before the first frame.
        pix(0, 0, 1'b1, 12'h000);
        pix(40, 40, 1'b1, BG);

        // One frame: box to (2,2), colour F00.
        frame(12'hF00, 1'b0);
        probe_box(2, 2, 12'hF00);
        pix(10, 10, 1'b0, 12'h000);          // blanked inside box
        pix(1, 480, 1'b0, 12'h000);          // not refr: x != 0
        pix(0, 479, 1'b0, 12'h000);          // not refr: y != V_DISPLAY
        @(negedge clk);
        x = 10'd0; y = 10'd480;              // refr position without p_tick
        repeat (2) @(negedge clk);

        // Paused frames: position held, colour and counter advance.
        frame(12'h0F0, 1'b1);
        pix(2, 2, 1'b1, 12'h0F0);
        frame(12'h0F0, 1'b1);
        frame(12'h0F0, 1'b1);
        probe_box(2, 2, 12'h0F0);
        chk("pause_fcnt", 32'(exp_fcnt), 32'd4);

        // X bounce at the right edge (moving frames 303..306).
        repeat (302) frame(12'h00F, 1'b0);
        probe_box(606, 292, 12'h00F);
        frame(12'h00F, 1'b0);
        probe_box(608, 290, 12'h00F);
        frame(12'h00F, 1'b0);
        probe_box(608, 288, 12'h00F);
        frame(12'h00F, 1'b0);
        probe_box(606, 286, 12'h00F);

        // Y bounce at the top edge (moving frames 448..451).
        repeat (142) frame(12'h00F, 1'b0);
        probe_box(322, 2, 12'h00F);
        frame(12'h00F, 1'b0);
        probe_box(320, 0, 12'h00F);
        frame(12'h00F, 1'b0);
        probe_box(318, 0, 12'h00F);
        frame(12'h00F, 1'b0);
        probe_box(316, 2, 12'h00F);

        // Asynchronous reset mid-line at frame_cnt 200.
        while (exp_fcnt != 8'd200) frame(12'h00F, 1'b0);
        pix(600, 10, 1'b1, BG);
        drain();
        chk("pre_reset_fcnt", 32'(frame_cnt), 32'd200);
        #2 reset = 1'b1;
        #1;
        chk("async_rgb", 32'(rgb), 32'h0);
        chk("async_frame_cnt", 32'(frame_cnt), 32'h0);
        exp_fcnt = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        pix(0, 0, 1'b1, 12'h000);
        pix(32, 0, 1'b1, BG);
        frame(12'hF00, 1'b0);
        probe_box(2, 2, 12'hF00);
        repeat (254) frame(12'hF00, 1'b0);
        drain();
        chk("fcnt_255", 32'(frame_cnt), 32'd255);
        frame(12'hF00, 1'b0);
        drain();
        chk("fcnt_wrap", 32'(frame_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
